// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch looks up combinationally; execute trains the table and raises a one-cycle redirect.
module branch_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 10
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_hit,
    output logic            lk_taken,
    output logic [XLEN-1:0] lk_target,
    input  logic            rs_valid,
    input  logic [1:0]      rs_kind,
    input  logic [XLEN-1:0] rs_pc,
    input  logic            rs_taken,
    input  logic [XLEN-1:0] rs_target,
    input  logic            rs_pred_taken,
    input  logic [XLEN-1:0] rs_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispred_cnt
);
    localparam int IDX = $clog2(ENTRIES);
    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_COND = 2'd2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX-1:0]   lk_idx, rs_idx;
    logic [TAG_W-1:0] lk_tag, rs_tag;
    logic             rs_hit, upd, wr_en, wr_tgt, mispred;
    logic [1:0]       ctr_cur, ctr_nxt;
    logic [XLEN-1:0]  rs_seq, actual, pred;

    assign lk_idx    = lk_pc[IDX+1:2];
    assign lk_tag    = lk_pc[IDX+1+TAG_W:IDX+2];
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ctr_q[lk_idx][1];
    assign lk_target = lk_taken ? tgt_q[lk_idx] : lk_pc + XLEN'(4);

    assign rs_idx  = rs_pc[IDX+1:2];
    assign rs_tag  = rs_pc[IDX+1+TAG_W:IDX+2];
    assign rs_hit  = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
    assign ctr_cur = ctr_q[rs_idx];
    assign upd     = rs_valid && (rs_kind != KIND_NONE);
    assign rs_seq  = rs_pc + XLEN'(4);
    assign actual  = rs_taken ? rs_target : rs_seq;
    assign pred    = rs_pred_taken ? rs_pred_target : rs_seq;
    assign mispred = upd && (actual != pred);

    // Unconditional jumps always (re)allocate strongly taken; conditional misses allocate only when taken.
    always_comb begin
        wr_en   = 1'b0;
        wr_tgt  = 1'b0;
        ctr_nxt = ctr_cur;
        if (upd) begin
            if (rs_kind != KIND_COND) begin
                wr_en   = 1'b1;
                wr_tgt  = 1'b1;
                ctr_nxt = 2'b11;
            end else if (rs_hit) begin
                wr_en = 1'b1;
                if (rs_taken) begin
                    wr_tgt = 1'b1;
                    if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
                end else if (ctr_cur != 2'b00) begin
                    ctr_nxt = ctr_cur - 2'd1;
                end
            end else if (rs_taken) begin
                wr_en   = 1'b1;
                wr_tgt  = 1'b1;
                ctr_nxt = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q     <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            mispred_cnt <= '0;
        end else begin
            if (wr_en) begin
                valid_q[rs_idx] <= 1'b1;
                ctr_q[rs_idx]   <= ctr_nxt;
            end
            redirect <= mispred;
            if (mispred) begin
                redirect_pc <= actual;
                if (mispred_cnt != 32'hFFFF_FFFF) mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

    // Tag and target payload carry no reset; valid_q guards them.
    always_ff @(posedge clk) begin
        if (wr_en) tag_q[rs_idx] <= rs_tag;
        if (wr_tgt) tgt_q[rs_idx] <= rs_target;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Randomised and directed check of branch_predictor against a behavioural table model.
module tb_branch_predictor;
    localparam int XLEN    = 64;
    localparam int ENTRIES = 16;
    localparam int TAG_W   = 10;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [XLEN-1:0] lk_pc = '0;
    logic            lk_hit, lk_taken;
    logic [XLEN-1:0] lk_target;
    logic            rs_valid = 1'b0;
    logic [1:0]      rs_kind = 2'd0;
    logic [XLEN-1:0] rs_pc = '0, rs_target = '0, rs_pred_target = '0;
    logic            rs_taken = 1'b0, rs_pred_taken = 1'b0;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     mispred_cnt;

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
        .lk_target(lk_target), .rs_valid(rs_valid), .rs_kind(rs_kind), .rs_pc(rs_pc),
        .rs_taken(rs_taken), .rs_target(rs_target), .rs_pred_taken(rs_pred_taken),
        .rs_pred_target(rs_pred_target), .redirect(redirect), .redirect_pc(redirect_pc),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: one record per table slot, plus the redirect/count registers.
    bit          m_valid [ENTRIES];
    longint      m_tag   [ENTRIES];
    logic [63:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_red;
    logic [63:0] m_rpc;
    logic [31:0] m_cnt;

    function automatic int slot(input logic [63:0] pc);
        return int'((pc / 64'd4) % 64'(ENTRIES));
    endfunction

    function automatic longint tag_of(input logic [63:0] pc);
        return longint'((pc / (64'd4 * 64'(ENTRIES))) % (64'd1 << TAG_W));
    endfunction

    function automatic bit m_hit(input logic [63:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_taken(input logic [63:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [63:0] m_next(input logic [63:0] pc);
        return m_taken(pc) ? m_tgt[slot(pc)] : pc + 64'd4;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_red = 1'b0;
        m_rpc = '0;
        m_cnt = '0;
    endfunction

    function automatic void model_update();
        int          s;
        logic [63:0] act, prd;
        m_red = 1'b0;
        if (!rs_valid || rs_kind == 2'd0) return;
        s   = slot(rs_pc);
        act = rs_taken ? rs_target : rs_pc + 64'd4;
        prd = rs_pred_taken ? rs_pred_target : rs_pc + 64'd4;
        if (rs_kind != 2'd2) begin
            m_valid[s] = 1'b1; m_tag[s] = tag_of(rs_pc); m_tgt[s] = rs_target; m_ctr[s] = 3;
        end else if (m_hit(rs_pc)) begin
            if (rs_taken) begin
                m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                m_tgt[s] = rs_target;
            end else begin
                m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end
        end else if (rs_taken) begin
            m_valid[s] = 1'b1; m_tag[s] = tag_of(rs_pc); m_tgt[s] = rs_target; m_ctr[s] = 2;
        end
        if (act != prd) begin
            m_red = 1'b1;
            m_rpc = act;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endfunction

    task automatic drive(input bit v, input logic [1:0] k, input logic [63:0] pc, input bit t,
                         input logic [63:0] tg, input bit pt, input logic [63:0] ptg);
        rs_valid = v; rs_kind = k; rs_pc = pc; rs_taken = t;
        rs_target = tg; rs_pred_taken = pt; rs_pred_target = ptg;
    endtask

    // Called one time unit after a rising edge with inputs already applied.
    task automatic cycle();
        #4;
        check("lk_hit", 64'(lk_hit), 64'(m_hit(lk_pc)));
        check("lk_taken", 64'(lk_taken), 64'(m_taken(lk_pc)));
        check("lk_target", lk_target, m_next(lk_pc));
        @(posedge clk);
        model_update();
        #1;
        check("redirect", 64'(redirect), 64'(m_red));
        check("redirect_pc", redirect_pc, m_rpc);
        check("mispred_cnt", 64'(mispred_cnt), 64'(m_cnt));
    endtask

    function automatic logic [63:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
        return 64'h8000_0000 + 64'(4 * $urandom_range(0, 63));
    endfunction

    initial begin
        logic [63:0] p;
        model_reset();
        #2;
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_cnt", 64'(mispred_cnt), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        lk_pc = 64'h8000_0000;
        cycle();
        check("post_rst_target", lk_target, 64'h8000_0004);

        drive(1, 2'd1, 64'h8000_0010, 1, 64'h8000_0100, 0, 64'h0);
        cycle();
        check("jal_redirect", 64'(redirect), 64'd1);
        check("jal_rpc", redirect_pc, 64'h8000_0100);
        check("jal_cnt", 64'(mispred_cnt), 64'd1);
        drive(0, 2'd0, 64'h0, 0, 64'h0, 0, 64'h0);
        lk_pc = 64'h8000_0010;
        #4;
        check("jal_lk_taken", 64'(lk_taken), 64'd1);
        check("jal_lk_target", lk_target, 64'h8000_0100);
        @(posedge clk); #1;

        drive(1, 2'd2, 64'h8000_0020, 1, 64'h8000_0040, 0, 64'h0);
        cycle();
        drive(1, 2'd2, 64'h8000_0020, 0, 64'h8000_0040, 1, 64'h8000_0040);
        cycle();
        drive(1, 2'd2, 64'h8000_0020, 0, 64'h8000_0040, 0, 64'h0);
        cycle();
        check("cond_no_redirect", 64'(redirect), 64'd0);
        drive(0, 2'd0, 64'h0, 0, 64'h0, 0, 64'h0);
        lk_pc = 64'h8000_0020;
        cycle();
        check("cond_nt_target", lk_target, 64'h8000_0024);

        drive(1, 2'd1, 64'h8000_0050, 1, 64'h8000_0200, 1, 64'h8000_0200);
        cycle();
        drive(0, 2'd0, 64'h0, 0, 64'h0, 0, 64'h0);
        lk_pc = 64'h8000_0010;
        cycle();
        check("alias_old_hit", 64'(lk_hit), 64'd0);

        lk_pc = 64'h8000_0030;
        drive(1, 2'd2, 64'h8000_0030, 1, 64'h8000_0300, 1, 64'h8000_0300);
        cycle();
        drive(0, 2'd0, 64'h0, 0, 64'h0, 0, 64'h0);
        cycle();
        check("same_cycle_next_taken", 64'(lk_taken), 64'd1);

        drive(1, 2'd0, 64'h8000_0040, 1, 64'h8000_0800, 0, 64'h0);
        cycle();
        check("kind0_redirect", 64'(redirect), 64'd0);

        for (int i = 0; i < 5; i++) begin
            p = 64'h8000_0000 + 64'(4 * i);
            drive(1, 2'd2, p, m_taken(p), m_next(p), m_taken(p), m_next(p));
            cycle();
        end

        for (int i = 0; i < 400; i++) begin
            logic [1:0] k;
            bit         t;
            logic [63:0] tg;
            p  = rand_pc();
            k  = 2'($urandom_range(0, 3));
            t  = (k == 2'd2) ? bit'($urandom_range(0, 1)) : 1'b1;
            tg = rand_pc();
            lk_pc = ($urandom_range(0, 3) == 0) ? p : rand_pc();
            if ($urandom_range(0, 1) == 1)
                drive($urandom_range(0, 4) != 0, k, p, t, tg, m_taken(p), m_next(p));
            else
                drive($urandom_range(0, 4) != 0, k, p, t, tg, bit'($urandom_range(0, 1)), rand_pc());
            cycle();
        end

        drive(1, 2'd3, 64'h8000_0060, 1, 64'h8000_0900, 0, 64'h0);
        cycle();
        check("pre_reset_redirect", 64'(redirect), 64'd1);
        drive(0, 2'd0, 64'h0, 0, 64'h0, 0, 64'h0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_redirect", 64'(redirect), 64'd0);
        check("async_reset_cnt", 64'(mispred_cnt), 64'd0);
        check("async_reset_rpc", redirect_pc, 64'd0);
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        lk_pc = 64'h8000_0060;
        drive(1, 2'd2, 64'h8000_0070, 1, 64'h8000_0A00, 0, 64'h0);
        cycle();
        check("after_reset_cnt", 64'(mispred_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
